// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Purpose  : Byte-stream program loader for the instruction memory. Parses a
//            framed stream of segments (address, word count, data words, all
//            big-endian) and issues one registered write per data word at its
//            PC-form byte address. A segment with count 0 ends the load.
// Ports    : clk, reset_n      - clock, asynchronous active-low reset
//            start             - begin a load (honoured in IDLE or DONE only)
//            rx_data/rx_valid  - stream byte and its valid flag
//            rx_ready          - loader accepts a byte this cycle
//            im_we/im_addr/im_wdata - one-cycle instruction-memory write
//            busy              - load in progress (core held in reset)
//            done              - load finished (level)
//            err               - sticky: at least one word was dropped
// Revision : 1.0 - initial release
// ============================================================================
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          SIZE      = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Size of the writable window in bytes.
  localparam logic [31:0] WIN_BYTES = 32'(4 * SIZE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CNT  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_bcnt;
  logic [23:0] r_sr;         // the three most recent bytes of the current word
  logic [31:0] r_cur_addr;
  logic [31:0] r_remaining;

  logic        w_accept;
  logic        w_word_done;
  logic [31:0] w_word;
  logic [31:0] w_off;
  logic        w_in_range;
  logic        w_start_ok;

  assign w_accept    = rx_valid && rx_ready;
  assign w_word_done = w_accept && (r_bcnt == 2'd3);
  assign w_word      = {r_sr, rx_data};
  // Addresses below the base wrap to a huge offset and so fail the bound.
  assign w_off       = r_cur_addr - BASE_ADDR;
  assign w_in_range  = (r_cur_addr[1:0] == 2'b00) && (w_off < WIN_BYTES);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ADDR;
      end
      S_ADDR: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (w_word_done) w_next = S_CNT;
      end
      S_CNT: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (w_word_done) w_next = (w_word == 32'd0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        // Last word of the segment: the next bytes are a new header.
        if (w_word_done && (r_remaining == 32'd1)) w_next = S_ADDR;
      end
      S_DONE: begin
        if (start) w_next = S_ADDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, header latching, memory write and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt      <= 2'd0;
      r_sr        <= 24'd0;
      r_cur_addr  <= 32'd0;
      r_remaining <= 32'd0;
      im_we       <= 1'b0;
      im_addr     <= 32'd0;
      im_wdata    <= 32'd0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (w_start_ok) begin
        done   <= 1'b0;
        err    <= 1'b0;
        r_bcnt <= 2'd0;
      end
      if (w_accept) begin
        r_bcnt <= r_bcnt + 2'd1;
        r_sr   <= w_word[23:0];
      end
      if (w_word_done) begin
        case (r_state)
          S_ADDR: r_cur_addr <= w_word;
          S_CNT: begin
            r_remaining <= w_word;
            if (w_word == 32'd0) done <= 1'b1;
          end
          S_DATA: begin
            if (w_in_range) begin
              im_we    <= 1'b1;
              im_addr  <= r_cur_addr;
              im_wdata <= w_word;
            end else begin
              err <= 1'b1;
            end
            r_cur_addr  <= r_cur_addr + 32'd4;
            r_remaining <= r_remaining - 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_loader
// Purpose  : Directed self-checking bench for im_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp;
  int n_bad;
  int cyc;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  im_loader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor samples on the falling edge.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wq_addr.push_back(im_addr);
      wq_data.push_back(im_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Present one byte with an optional idle gap; returns on the falling edge
  // right after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    send_byte(w[31:24], max_gap);
    send_byte(w[23:16], max_gap);
    send_byte(w[15:8],  max_gap);
    send_byte(w[7:0],   max_gap);
  endtask

  task automatic idle_rx();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    idle_rx();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_end(input string nm, input logic exp_err);
    n_cmp++;
    if ({done, err, busy, rx_ready} !== {1'b1, exp_err, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_status: done/err/busy/rdy=%b%b%b%b required 1%b00",
               nm, done, err, busy, rx_ready, exp_err);
    end
  endtask

  // Basic two-word load; start_mid pulses start partway through DATA.
  task automatic basic_load(input string nm, input int max_gap, input bit start_mid);
    clear_q();
    pulse_start();
    send_word(32'h0000_3000, max_gap);
    send_word(32'h0000_0002, max_gap);
    send_byte(8'h3C, max_gap);
    send_byte(8'h01, max_gap);
    if (start_mid) begin
      idle_rx();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
        n_bad++;
        $display("FAIL %s_start_in_data: busy/done=%b%b required 10", nm, busy, done);
      end
    end
    send_byte(8'h00, max_gap);
    send_byte(8'h00, max_gap);
    n_cmp++;
    if (im_we !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_we_latency: im_we=%b required 1", nm, im_we);
    end
    send_word(32'h3421_0001, max_gap);
    send_word(32'h0000_0000, max_gap);
    send_word(32'h0000_0000, max_gap);
    idle_rx();
    check_end(nm, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wq_addr.size() != 2) begin
      n_bad++;
      $display("FAIL %s_nwrites: got %0d required 2", nm, wq_addr.size());
    end else begin
      n_cmp++;
      if ({wq_addr[0], wq_data[0]} !== {32'h0000_3000, 32'h3C01_0000}) begin
        n_bad++;
        $display("FAIL %s_w0: addr=%h data=%h required 00003000 3c010000", nm, wq_addr[0], wq_data[0]);
      end
      n_cmp++;
      if ({wq_addr[1], wq_data[1]} !== {32'h0000_3004, 32'h3421_0001}) begin
        n_bad++;
        $display("FAIL %s_w1: addr=%h data=%h required 00003004 34210001", nm, wq_addr[1], wq_data[1]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({rx_ready, im_we, im_addr, im_wdata, busy, done, err} !== 69'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b required all 0",
               rx_ready, im_we, im_addr, im_wdata, busy, done, err);
    end
  endtask

  task automatic test_basic();
    basic_load("basic", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    basic_load("b2b", 0, 1'b0);
    if (wq_cyc.size() == 2) begin
      n_cmp++;
      if (wq_cyc[1] - wq_cyc[0] != 4) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d cycles required 4", wq_cyc[1] - wq_cyc[0]);
      end
    end
  endtask

  task automatic test_two_segments();
    clear_q();
    pulse_start();
    send_word(32'h0000_3000, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_4180, 0);
    send_word(32'h0000_0001, 0);
    send_word(32'h4200_0018, 0);
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_0000, 0);
    idle_rx();
    check_end("twoseg", 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wq_addr.size() != 2) begin
      n_bad++;
      $display("FAIL twoseg_nwrites: got %0d required 2", wq_addr.size());
    end else begin
      n_cmp++;
      if ({wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]} !==
          {32'h0000_3000, 32'h0000_0000, 32'h0000_4180, 32'h4200_0018}) begin
        n_bad++;
        $display("FAIL twoseg_writes: %h/%h %h/%h required 00003000/00000000 00004180/42000018",
                 wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
  endtask

  // One-segment load expected to drop every word.
  task automatic drop_load(input string nm, input logic [31:0] a, input logic [31:0] cnt);
    clear_q();
    pulse_start();
    send_word(a, 0);
    send_word(cnt, 0);
    for (int i = 0; i < int'(cnt); i++) send_word(32'hDEAD_0000 + 32'(i), 0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_err_timing: err=%b required 1", nm, err);
    end
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_0000, 0);
    idle_rx();
    check_end(nm, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wq_addr.size() != 0) begin
      n_bad++;
      $display("FAIL %s_nwrites: got %0d required 0", nm, wq_addr.size());
    end
  endtask

  task automatic test_out_of_range();
    drop_load("oor_hi", 32'h0000_7000, 32'd1);
    drop_load("oor_lo", 32'h0000_2FFC, 32'd1);
    drop_load("misalign", 32'h0000_3002, 32'd2);
  endtask

  // Last word of the window is written, the one after it is dropped.
  task automatic test_top_boundary();
    clear_q();
    pulse_start();
    send_word(32'h0000_6FFC, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h1111_2222, 0);
    send_word(32'h3333_4444, 0);
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_0000, 0);
    idle_rx();
    check_end("topbnd", 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wq_addr.size() != 1) begin
      n_bad++;
      $display("FAIL topbnd_nwrites: got %0d required 1", wq_addr.size());
    end else begin
      n_cmp++;
      if ({wq_addr[0], wq_data[0]} !== {32'h0000_6FFC, 32'h1111_2222}) begin
        n_bad++;
        $display("FAIL topbnd_w0: addr=%h data=%h required 00006ffc 11112222", wq_addr[0], wq_data[0]);
      end
    end
  endtask

  task automatic test_start_in_done();
    // err=1 and done=1 remain from the previous load.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({done, err, busy} !== 3'b001) begin
      n_bad++;
      $display("FAIL start_done_clear: done/err/busy=%b%b%b required 001", done, err, busy);
    end
    send_word(32'h0000_0000, 0);
    send_word(32'h0000_0000, 0);
    idle_rx();
    check_end("restart", 1'b0);
  endtask

  task automatic test_stall();
    basic_load("stall", 3, 1'b0);
  endtask

  task automatic test_start_in_data();
    basic_load("startdata", 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    clear_q();
    pulse_start();
    send_word(32'h0000_3000, 0);
    send_word(32'h0000_0002, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h01, 0);
    reset_n = 1'b0;
    idle_rx();
    #1;
    n_cmp++;
    if ({rx_ready, im_we, im_addr, im_wdata, busy, done, err} !== 69'd0) begin
      n_bad++;
      $display("FAIL resetmid_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b required all 0",
               rx_ready, im_we, im_addr, im_wdata, busy, done, err);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wq_addr.size() != 0 || rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL resetmid_nowrite: writes=%0d rdy=%b required 0 0", wq_addr.size(), rx_ready);
    end
    basic_load("afterreset", 0, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_two_segments();
    test_out_of_range();
    test_top_boundary();
    test_start_in_done();
    test_stall();
    test_start_in_data();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/im_loader.md
# im_loader

Byte-stream program loader that fills the instruction memory before the CPU runs. It writes the memory that the fetch path reads combinationally by PC. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written to the memory at its PC-form byte address (code at 0x3000, exception handler at 0x4180). `busy` is held high during loading so the core can be kept in reset.

## Interface
- BASE_ADDR, 32'h0000_3000, byte address of instruction memory word 0
- SIZE, 4096, memory depth in 32-bit words; valid window is [BASE_ADDR, BASE_ADDR+4*SIZE)

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- im_we  out  1  one-cycle memory write strobe
- im_addr  out  32  write byte address (PC form, word-aligned)
- im_wdata  out  32  write data
- busy  out  1  load in progress
- done  out  1  load finished (level)
- err  out  1  sticky: at least one word was dropped

## Operation
- Stream format is a sequence of segments. Each segment is:
  - a 4-byte start address, MSB first;
  - a 4-byte word count, MSB first;
  - count × 4 data bytes, each word MSB first.
- A segment with count 0 terminates the load.
- A byte is accepted when rx_valid && rx_ready. A 2-bit byte counter shifts bytes into a 32-bit shift register: sr = {sr[23:0], rx_data}.
- States and transitions:
  - IDLE: start moves to ADDR.
  - ADDR: after the 4th byte, latch cur_addr and go to CNT.
  - CNT: after the 4th byte, latch remaining. If remaining==0 go to DONE, else go to DATA.
  - DATA: after each 4th byte, issue a write, then cur_addr += 4 (mod 2^32) and remaining -= 1. When remaining reaches 0, return to ADDR.
  - DONE: start moves to ADDR.
- rx_ready = 1 in ADDR, CNT and DATA; 0 in IDLE and DONE. Asserting busy is equivalent to being in ADDR, CNT or DATA.
- Word check at each write uses off = cur_addr − BASE_ADDR (32-bit unsigned). The word is in range iff cur_addr[1:0]==0 and off < 4*SIZE.
  - Addresses below base wrap to a large offset and fail the check.
  - Failing words are consumed but not written; err is set.
- start clears done and err when leaving IDLE or DONE. start is ignored while busy.
- Count is a full 32-bit value. There is no limit other than stream length.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - state IDLE;
  - rx_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0;
  - byte counter, cur_addr and remaining all 0.
- im_we, im_addr and im_wdata are registered. They are asserted in the cycle after the handshake of a word's 4th byte, for exactly one cycle. im_addr/im_wdata hold their last value afterwards.
- No backpressure from memory: rx_ready stays 1 through write cycles, so one byte per cycle is sustained. Back-to-back words give an im_we pulse every 4 cycles.
- busy rises the cycle after start. done rises the cycle after the 4th byte of a zero count; busy falls in the same cycle.
- err rises in the same cycle the dropped word's im_we would have asserted.
- rx_valid gaps between bytes are allowed anywhere and only stretch timing.
- reset_n low mid-operation aborts immediately. Any partial word is discarded, no write is issued, and all outputs return to reset values.

## Test plan
- Basic load:
  - Stimulus: start; bytes 00 00 30 00 | 00 00 00 02 | 3C 01 00 00 | 34 21 00 01 | 00 00 00 00 | 00 00 00 00.
  - Required: im_we at addr 0x3000 data 0x3C010000, then at addr 0x3004 data 0x34210001; done=1, err=0, busy=0, rx_ready=0.
- Two segments (0x3000 ×1 word 0x00000000, 0x4180 ×1 word 0x42000018, then terminator):
  - Required: exactly two writes at 0x3000 and 0x4180 with matching data.
- Out of range:
  - Stimulus: segment addr 0x00007000, 1 word; second test with addr 0x00002FFC.
  - Required: no im_we, err=1, load still reaches DONE.
- Misaligned addr 0x00003002, count 2:
  - Required: 8 data bytes consumed, no im_we, err=1, done=1.
- Stall and reset:
  - Stimulus: random rx_valid gaps in the basic load.
  - Required: identical writes.
  - Stimulus: reset_n pulsed low after 2 data bytes.
  - Required: all outputs 0 and no write. A fresh start + basic stream then loads correctly.
- Control:
  - Stimulus: start pulsed during DATA.
  - Required: ignored, load unaffected.
  - Stimulus: start in DONE with err=1.
  - Required: done and err clear, busy=1 next cycle.
